fetch_redirect_ctrl: RTL and testbench
======================================

# fetch_redirect_ctrl

Sequencing controller for the fetch stage of the 10-bit-PC pipelined core. Each cycle it decides the next PC from these redirect sources: EX-stage branch mispredict, ID-stage jr, jump, predicted-taken branch, and load-use stall. It also drives the PC hold and the IF/ID and ID/EX flush/hold controls. A small state machine handles jr operand waits and one-cycle mispredict recovery, and saturating counters track branch and mispredict statistics.

## Interface
- AW, 10, PC/address width
- CW, 16, statistics counter width
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-low
- pc_plus1  in  AW  current PC + 1 from the fetch adder
- id_opcode  in  6  opcode of the instruction in IF/ID
- id_target  in  AW  jump target field from IF/ID
- id_pred_taken  in  1  BPU prediction for the branch in ID
- id_pred_target  in  AW  BPU/computed target for the branch in ID
- id_jr  in  1  IF/ID holds a jr
- jr_ready  in  1  jr source register is available (forwarded or written)
- jr_addr  in  AW  jr target
- load_use_stall  in  1  hazard unit load-use stall request
- ex_branch  in  1  a conditional branch is resolving in EX
- ex_taken  in  1  actual outcome
- ex_pred_taken  in  1  prediction carried down the pipe
- ex_target  in  AW  actual taken target
- ex_pcplus1  in  AW  fall-through address of the EX branch
- next_pc  out  AW  PC register input
- pc_sel  out  3  0 seq, 1 jump, 2 pred-branch, 3 jr, 4 recover-fallthrough, 5 recover-target, 6 hold/reset
- pc_hold  out  1  PC keeps its value
- ifid_hold  out  1  IF/ID keeps its value
- flush_ifid  out  1  IF/ID loads a bubble
- flush_idex  out  1  ID/EX loads a bubble
- state  out  2  0 IDLE, 1 RUN, 2 JR_WAIT, 3 RECOVER
- branch_cnt  out  CW  resolved branches, saturating
- mispredict_cnt  out  CW  mispredicts, saturating

## Operation
- Outputs other than `state` and the counters are combinational from the registered state and the current inputs. `state` and the counters are registered.
- **mispredict** = `ex_branch & (ex_taken != ex_pred_taken)`.
- **IDLE**: entered on reset and held for exactly one cycle after `rst` rises.
  - `next_pc` = 0, `pc_sel` = 6, `pc_hold` = 1, `flush_ifid` = 1.
  - Then goes to RUN.
- **RUN**: first matching rule applies, in this priority order:
  1. mispredict: `next_pc` = `ex_taken ? ex_target : ex_pcplus1`, `pc_sel` = 5/4, `flush_ifid` = `flush_idex` = 1; go to RECOVER.
  2. `id_jr & !jr_ready`: `pc_hold` = `ifid_hold` = 1, `flush_idex` = 1, `pc_sel` = 6; go to JR_WAIT.
  3. `id_jr & jr_ready`: `next_pc` = `jr_addr`, `pc_sel` = 3, `flush_ifid` = 1.
  4. `load_use_stall`: `pc_hold` = `ifid_hold` = 1, `flush_idex` = 1, `pc_sel` = 6.
  5. `id_opcode` 0x02/0x03: `next_pc` = `id_target`, `pc_sel` = 1, `flush_ifid` = 1.
  6. `id_opcode` 0x04/0x05 & `id_pred_taken`: `next_pc` = `id_pred_target`, `pc_sel` = 2, `flush_ifid` = 1.
  7. otherwise: `next_pc` = `pc_plus1`, `pc_sel` = 0.
- **JR_WAIT**:
  - mispredict behaves as rule 1 and squashes the jr.
  - Else if `jr_ready`: as rule 3, then go to RUN.
  - Else remain in JR_WAIT with holds as rule 2.
  - No timeout.
- **RECOVER**: lasts one cycle.
  - All ID and EX inputs are ignored, because both stages hold bubbles.
  - `next_pc` = `pc_plus1`, `pc_sel` = 0; then go to RUN.
- When `pc_hold` = 1, `next_pc` = `pc_plus1` − 1 (the current PC), so a PC register without a hold input still behaves correctly.
- Address arithmetic is modulo 2^AW: `pc_plus1` = 0 wraps and is used as-is; targets are never range-checked.
- Counters:
  - `branch_cnt` increments on `ex_branch` in RUN/JR_WAIT.
  - `mispredict_cnt` increments on mispredict.
  - Both saturate at 2^CW − 1.

## Timing
- While `rst` = 0 on a rising edge:
  - State goes to IDLE and both counters clear.
  - Combinationally during reset: `next_pc` = 0, `pc_sel` = 6, `pc_hold` = 0, `ifid_hold` = 0, `flush_ifid` = `flush_idex` = 1.
- A reset asserted mid-JR_WAIT or mid-RECOVER abandons the state at that edge.
- Redirect latency: a redirect decided in cycle N takes effect when PC loads `next_pc` at the edge ending cycle N. The first redirected instruction reaches IF/ID one cycle later.
- Redirect penalties:
  - Mispredict: 2 bubbles (IF/ID and ID/EX flushed) plus the RECOVER cycle.
  - Jump/jr/predicted branch: 1 bubble.
- Simultaneous events resolve strictly by the priority list above. A mispredict always wins, including over a load-use stall in the same cycle.

## Test plan
- Reset: hold `rst` = 0 for 2 cycles with `pc_plus1` = 0x05 -> `next_pc` = 0, `flush_ifid` = 1, counters 0; after release one IDLE cycle, then RUN with `pc_sel` = 0.
- Jump: `id_opcode` = 0x02, `id_target` = 0x3A0 -> `next_pc` = 0x3A0, `pc_sel` = 1, `flush_ifid` = 1 for one cycle.
- Mispredict vs. load-use: `ex_branch` = 1, `ex_taken` = 1, `ex_pred_taken` = 0, `ex_target` = 0x120, `load_use_stall` = 1 -> `next_pc` = 0x120, `pc_sel` = 5, both flushes asserted, `pc_hold` = 0, next state RECOVER, `mispredict_cnt` = 1.
- jr wait: `id_jr` = 1, `jr_ready` = 0 for 3 cycles, then 1 with `jr_addr` = 0x044 -> 3 cycles of `pc_hold` = `ifid_hold` = 1 in JR_WAIT, then `next_pc` = 0x044, `pc_sel` = 3, return to RUN.
- Wrap: `pc_plus1` = 0x000 with no redirect -> `next_pc` = 0x000. With `load_use_stall` -> `next_pc` = 0x3FF, `pc_hold` = 1.
- Saturation: force 65 540 branch resolutions, every one mispredicted -> both counters stick at 0xFFFF.

Source files
------------

// File: rtl/fetch_redirect_ctrl_if.sv
// Signal bundle between the fetch redirect controller and the surrounding pipeline.
// The pipeline side is the master (drives hazard/branch info); the controller is the slave.
interface fetch_redirect_ctrl_if #(
    parameter int AW = 10,
    parameter int CW = 16
);
    logic [AW-1:0] pc_plus1;
    logic [5:0]    id_opcode;
    logic [AW-1:0] id_target;
    logic          id_pred_taken;
    logic [AW-1:0] id_pred_target;
    logic          id_jr;
    logic          jr_ready;
    logic [AW-1:0] jr_addr;
    logic          load_use_stall;
    logic          ex_branch;
    logic          ex_taken;
    logic          ex_pred_taken;
    logic [AW-1:0] ex_target;
    logic [AW-1:0] ex_pcplus1;

    logic [AW-1:0] next_pc;
    logic [2:0]    pc_sel;
    logic          pc_hold;
    logic          ifid_hold;
    logic          flush_ifid;
    logic          flush_idex;
    logic [1:0]    state;
    logic [CW-1:0] branch_cnt;
    logic [CW-1:0] mispredict_cnt;

    modport master (
        output pc_plus1, id_opcode, id_target, id_pred_taken, id_pred_target,
               id_jr, jr_ready, jr_addr, load_use_stall,
               ex_branch, ex_taken, ex_pred_taken, ex_target, ex_pcplus1,
        input  next_pc, pc_sel, pc_hold, ifid_hold, flush_ifid, flush_idex,
               state, branch_cnt, mispredict_cnt
    );

    modport slave (
        input  pc_plus1, id_opcode, id_target, id_pred_taken, id_pred_target,
               id_jr, jr_ready, jr_addr, load_use_stall,
               ex_branch, ex_taken, ex_pred_taken, ex_target, ex_pcplus1,
        output next_pc, pc_sel, pc_hold, ifid_hold, flush_ifid, flush_idex,
               state, branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage next-PC selection with jr-wait / mispredict-recovery sequencing
// and saturating branch statistics.
module fetch_redirect_ctrl #(
    parameter int AW = 10,
    parameter int CW = 16
) (
    input logic                 clk,
    input logic                 rst,
    fetch_redirect_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_JR_WAIT = 2'd2,
        ST_RECOVER = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        SEL_SEQ      = 3'd0,
        SEL_JUMP     = 3'd1,
        SEL_PRED_BR  = 3'd2,
        SEL_JR       = 3'd3,
        SEL_REC_FALL = 3'd4,
        SEL_REC_TGT  = 3'd5,
        SEL_HOLD     = 3'd6
    } pc_sel_e;

    state_e        state_q, state_d;
    logic [CW-1:0] branch_cnt_q, branch_cnt_d;
    logic [CW-1:0] mispredict_cnt_q, mispredict_cnt_d;

    logic          mispredict;
    logic          is_jump;
    logic          is_branch;
    logic          count_en;
    logic [AW-1:0] cur_pc;

    assign mispredict = bus.ex_branch & (bus.ex_taken != bus.ex_pred_taken);
    assign is_jump    = (bus.id_opcode == 6'h02) || (bus.id_opcode == 6'h03);
    assign is_branch  = (bus.id_opcode == 6'h04) || (bus.id_opcode == 6'h05);
    // Holding PC re-presents the current address, which wraps like the adder.
    assign cur_pc     = bus.pc_plus1 - AW'(1);
    // EX results are only meaningful while the pipe is flowing; RECOVER holds bubbles.
    assign count_en   = (state_q == ST_RUN) || (state_q == ST_JR_WAIT);

    // NOTE: every output gets a default first so no path through the case leaves a latch.
    always_comb begin
        bus.next_pc    = bus.pc_plus1;
        bus.pc_sel     = SEL_SEQ;
        bus.pc_hold    = 1'b0;
        bus.ifid_hold  = 1'b0;
        bus.flush_ifid = 1'b0;
        bus.flush_idex = 1'b0;
        state_d        = state_q;

        if (!rst) begin
            bus.next_pc    = '0;
            bus.pc_sel     = SEL_HOLD;
            bus.flush_ifid = 1'b1;
            bus.flush_idex = 1'b1;
            state_d        = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    bus.next_pc    = '0;
                    bus.pc_sel     = SEL_HOLD;
                    bus.pc_hold    = 1'b1;
                    bus.flush_ifid = 1'b1;
                    state_d        = ST_RUN;
                end

                ST_RUN, ST_JR_WAIT: begin
                    state_d = ST_RUN;
                    if (mispredict) begin
                        bus.next_pc    = bus.ex_taken ? bus.ex_target : bus.ex_pcplus1;
                        bus.pc_sel     = bus.ex_taken ? SEL_REC_TGT : SEL_REC_FALL;
                        bus.flush_ifid = 1'b1;
                        bus.flush_idex = 1'b1;
                        state_d        = ST_RECOVER;
                    end else if (bus.id_jr || state_q == ST_JR_WAIT) begin
                        if (bus.jr_ready) begin
                            bus.next_pc    = bus.jr_addr;
                            bus.pc_sel     = SEL_JR;
                            bus.flush_ifid = 1'b1;
                        end else begin
                            bus.next_pc    = cur_pc;
                            bus.pc_sel     = SEL_HOLD;
                            bus.pc_hold    = 1'b1;
                            bus.ifid_hold  = 1'b1;
                            bus.flush_idex = 1'b1;
                            state_d        = ST_JR_WAIT;
                        end
                    end else if (bus.load_use_stall) begin
                        bus.next_pc    = cur_pc;
                        bus.pc_sel     = SEL_HOLD;
                        bus.pc_hold    = 1'b1;
                        bus.ifid_hold  = 1'b1;
                        bus.flush_idex = 1'b1;
                    end else if (is_jump) begin
                        bus.next_pc    = bus.id_target;
                        bus.pc_sel     = SEL_JUMP;
                        bus.flush_ifid = 1'b1;
                    end else if (is_branch && bus.id_pred_taken) begin
                        bus.next_pc    = bus.id_pred_target;
                        bus.pc_sel     = SEL_PRED_BR;
                        bus.flush_ifid = 1'b1;
                    end
                end

                ST_RECOVER: begin
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    always_comb begin
        branch_cnt_d     = branch_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        if (count_en && bus.ex_branch && branch_cnt_q != '1)
            branch_cnt_d = branch_cnt_q + CW'(1);
        if (count_en && mispredict && mispredict_cnt_q != '1)
            mispredict_cnt_d = mispredict_cnt_q + CW'(1);
    end

    // NOTE: state registers use non-blocking assignment so all of them sample the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            state_q          <= state_d;
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign bus.state          = state_q;
    assign bus.branch_cnt     = branch_cnt_q;
    assign bus.mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Table-driven bench for fetch_redirect_ctrl: each row drives one cycle of inputs and
// queues the expected combinational outputs plus the registered state/counters after the edge.
module tb_fetch_redirect_ctrl;

    localparam int AW = 10;
    // Narrow counters so saturation is reachable in a few hundred cycles.
    localparam int CW = 8;

    logic clk;
    logic rst;

    fetch_redirect_ctrl_if #(.AW(AW), .CW(CW)) bus ();

    fetch_redirect_ctrl #(.AW(AW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int rst;
        int pc1, opc, tgt, ptk, ptgt;
        int jr, jrr, jra, lus;
        int exb, ext, eptk, extgt, expc1;
        int npc, sel, hold, ifh, fif, fid;
        int st, bc, mc;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv)
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        else
            n_pass++;
    endtask

    task automatic run_vec(input vec_t v);
        vec_t e;
        rst                = v.rst[0];
        bus.pc_plus1       = AW'(v.pc1);
        bus.id_opcode      = 6'(v.opc);
        bus.id_target      = AW'(v.tgt);
        bus.id_pred_taken  = v.ptk[0];
        bus.id_pred_target = AW'(v.ptgt);
        bus.id_jr          = v.jr[0];
        bus.jr_ready       = v.jrr[0];
        bus.jr_addr        = AW'(v.jra);
        bus.load_use_stall = v.lus[0];
        bus.ex_branch      = v.exb[0];
        bus.ex_taken       = v.ext[0];
        bus.ex_pred_taken  = v.eptk[0];
        bus.ex_target      = AW'(v.extgt);
        bus.ex_pcplus1     = AW'(v.expc1);
        exp_q.push_back(v);

        @(negedge clk);
        e = exp_q.pop_front();
        check({e.name, ".next_pc"},    32'(bus.next_pc),    32'(e.npc));
        check({e.name, ".pc_sel"},     32'(bus.pc_sel),     32'(e.sel));
        check({e.name, ".pc_hold"},    32'(bus.pc_hold),    32'(e.hold));
        check({e.name, ".ifid_hold"},  32'(bus.ifid_hold),  32'(e.ifh));
        check({e.name, ".flush_ifid"}, 32'(bus.flush_ifid), 32'(e.fif));
        check({e.name, ".flush_idex"}, 32'(bus.flush_idex), 32'(e.fid));

        @(posedge clk);
        #1;
        check({e.name, ".state"},          32'(bus.state),          32'(e.st));
        check({e.name, ".branch_cnt"},     32'(bus.branch_cnt),     32'(e.bc));
        check({e.name, ".mispredict_cnt"}, 32'(bus.mispredict_cnt), 32'(e.mc));
    endtask

    initial begin
        //            name         rst pc1    opc   tgt    ptk ptgt   jr jrr jra    lus exb ext eptk extgt  expc1    npc    sel hld ifh fif fid  st bc mc
        vecs.push_back('{"rst_a",     0, 'h005, 0,    0,     0, 0,     0, 0,  0,     0,  0,  0,  0,   0,     0,       0,     6,  0,  0,  1,  1,   0, 0, 0});
        vecs.push_back('{"rst_b",     0, 'h005, 0,    0,     0, 0,     0, 0,  0,     0,  0,  0,  0,   0,     0,       0,     6,  0,  0,  1,  1,   0, 0, 0});
        vecs.push_back('{"idle",      1, 'h005, 0,    0,     0, 0,     0, 0,  0,     0,  0,  0,  0,   0,     0,       0,     6,  1,  0,  1,  0,   1, 0, 0});
        vecs.push_back('{"seq",       1, 'h006, 0,    0,     0, 0,     0, 0,  0,     0,  0,  0,  0,   0,     0,       'h006, 0,  0,  0,  0,  0,   1, 0, 0});
        vecs.push_back('{"jump02",    1, 'h007, 'h02, 'h3A0, 0, 0,     0, 0,  0,     0,  0,  0,  0,   0,     0,       'h3A0, 1,  0,  0,  1,  0,   1, 0, 0});
        vecs.push_back('{"jump03",    1, 'h008, 'h03, 'h155, 0, 0,     0, 0,  0,     0,  0,  0,  0,   0,     0,       'h155, 1,  0,  0,  1,  0,   1, 0, 0});
        vecs.push_back('{"pred04",    1, 'h009, 'h04, 'h155, 1, 'h2B0, 0, 0,  0,     0,  0,  0,  0,   0,     0,       'h2B0, 2,  0,  0,  1,  0,   1, 0, 0});
        vecs.push_back('{"nopred05",  1, 'h010, 'h05, 0,     0, 'h2B0, 0, 0,  0,     0,  0,  0,  0,   0,     0,       'h010, 0,  0,  0,  0,  0,   1, 0, 0});
        vecs.push_back('{"opc06",     1, 'h011, 'h06, 'h155, 1, 'h2B0, 0, 0,  0,     0,  0,  0,  0,   0,     0,       'h011, 0,  0,  0,  0,  0,   1, 0, 0});
        vecs.push_back('{"lus_jump",  1, 'h012, 'h02, 'h3A0, 0, 0,     0, 0,  0,     1,  0,  0,  0,   0,     0,       'h011, 6,  1,  1,  0,  1,   1, 0, 0});
        vecs.push_back('{"jr_lus",    1, 'h013, 0,    0,     0, 0,     1, 1,  'h200, 1,  0,  0,  0,   0,     0,       'h200, 3,  0,  0,  1,  0,   1, 0, 0});
        vecs.push_back('{"good_br",   1, 'h020, 0,    0,     0, 0,     0, 0,  0,     0,  1,  1,  1,   'h300, 'h050,   'h020, 0,  0,  0,  0,  0,   1, 1, 0});
        vecs.push_back('{"mp_lus",    1, 'h021, 0,    0,     0, 0,     0, 0,  0,     1,  1,  1,  0,   'h120, 'h050,   'h120, 5,  0,  0,  1,  1,   3, 2, 1});
        vecs.push_back('{"recover",   1, 'h121, 'h02, 'h3A0, 0, 0,     1, 1,  'h200, 1,  1,  0,  1,   'h333, 'h0AB,   'h121, 0,  0,  0,  0,  0,   1, 2, 1});
        vecs.push_back('{"mp_fall",   1, 'h130, 0,    0,     0, 0,     1, 0,  0,     0,  1,  0,  1,   'h333, 'h0AB,   'h0AB, 4,  0,  0,  1,  1,   3, 3, 2});
        vecs.push_back('{"recover_b", 1, 'h0AC, 0,    0,     0, 0,     0, 0,  0,     0,  0,  0,  0,   0,     0,       'h0AC, 0,  0,  0,  0,  0,   1, 3, 2});
        vecs.push_back('{"jr_enter",  1, 'h0AD, 0,    0,     0, 0,     1, 0,  'h044, 0,  0,  0,  0,   0,     0,       'h0AC, 6,  1,  1,  0,  1,   2, 3, 2});
        vecs.push_back('{"jr_wait1",  1, 'h0AD, 'h02, 'h3A0, 0, 0,     1, 0,  'h044, 0,  0,  0,  0,   0,     0,       'h0AC, 6,  1,  1,  0,  1,   2, 3, 2});
        vecs.push_back('{"jr_wait2",  1, 'h0AD, 0,    0,     0, 0,     1, 0,  'h044, 0,  1,  1,  1,   'h300, 'h050,   'h0AC, 6,  1,  1,  0,  1,   2, 4, 2});
        vecs.push_back('{"jr_wait3",  1, 'h0AD, 0,    0,     0, 0,     1, 0,  'h044, 1,  0,  0,  0,   0,     0,       'h0AC, 6,  1,  1,  0,  1,   2, 4, 2});
        vecs.push_back('{"jr_go",     1, 'h0AD, 0,    0,     0, 0,     1, 1,  'h044, 0,  0,  0,  0,   0,     0,       'h044, 3,  0,  0,  1,  0,   1, 4, 2});
        vecs.push_back('{"wrap",      1, 'h000, 0,    0,     0, 0,     0, 0,  0,     0,  0,  0,  0,   0,     0,       'h000, 0,  0,  0,  0,  0,   1, 4, 2});
        vecs.push_back('{"wrap_lus",  1, 'h000, 0,    0,     0, 0,     0, 0,  0,     1,  0,  0,  0,   0,     0,       'h3FF, 6,  1,  1,  0,  1,   1, 4, 2});
        vecs.push_back('{"jw_enter",  1, 'h050, 0,    0,     0, 0,     1, 0,  0,     0,  0,  0,  0,   0,     0,       'h04F, 6,  1,  1,  0,  1,   2, 4, 2});
        vecs.push_back('{"jw_mp",     1, 'h050, 0,    0,     0, 0,     1, 1,  'h044, 0,  1,  1,  0,   'h3F0, 'h051,   'h3F0, 5,  0,  0,  1,  1,   3, 5, 3});
        vecs.push_back('{"recover_c", 1, 'h3F1, 0,    0,     0, 0,     0, 0,  0,     0,  0,  0,  0,   0,     0,       'h3F1, 0,  0,  0,  0,  0,   1, 5, 3});
        vecs.push_back('{"jw_enter2", 1, 'h060, 0,    0,     0, 0,     1, 0,  0,     0,  0,  0,  0,   0,     0,       'h05F, 6,  1,  1,  0,  1,   2, 5, 3});
        vecs.push_back('{"rst_jw",    0, 'h060, 0,    0,     0, 0,     1, 1,  'h044, 0,  0,  0,  0,   0,     0,       0,     6,  0,  0,  1,  1,   0, 0, 0});
        vecs.push_back('{"idle_b",    1, 'h001, 0,    0,     0, 0,     0, 0,  0,     0,  0,  0,  0,   0,     0,       0,     6,  1,  0,  1,  0,   1, 0, 0});
        vecs.push_back('{"mp_enter",  1, 'h002, 0,    0,     0, 0,     0, 0,  0,     0,  1,  1,  0,   'h111, 'h010,   'h111, 5,  0,  0,  1,  1,   3, 1, 1});
        vecs.push_back('{"rst_rec",   0, 'h112, 0,    0,     0, 0,     0, 0,  0,     0,  0,  0,  0,   0,     0,       0,     6,  0,  0,  1,  1,   0, 0, 0});
        vecs.push_back('{"idle_c",    1, 'h112, 0,    0,     0, 0,     0, 0,  0,     0,  0,  0,  0,   0,     0,       0,     6,  1,  0,  1,  0,   1, 0, 0});
        vecs.push_back('{"pred_wrap", 1, 'h3FF, 'h05, 0,     1, 'h3FF, 0, 0,  0,     0,  0,  0,  0,   0,     0,       'h3FF, 2,  0,  0,  1,  0,   1, 0, 0});

        @(posedge clk);
        #1;
        foreach (vecs[i]) run_vec(vecs[i]);

        // Saturation: every resolution mispredicted, each followed by its RECOVER cycle.
        for (int i = 0; i < (1 << CW) + 4; i++) begin
            vec_t mp;
            vec_t rc;
            int   cnt;
            cnt = (i + 1 > (1 << CW) - 1) ? (1 << CW) - 1 : i + 1;
            mp = '{"sat_mp", 1, 'h100, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h2AA, 'h101,
                   'h101, 4, 0, 0, 1, 1, 3, cnt, cnt};
            rc = '{"sat_rec", 1, 'h102, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h2AA, 'h101,
                   'h102, 0, 0, 0, 0, 0, 1, cnt, cnt};
            run_vec(mp);
            run_vec(rc);
        end
        check("sat.branch_cnt_final",     32'(bus.branch_cnt),     32'hFF);
        check("sat.mispredict_cnt_final", 32'(bus.mispredict_cnt), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
